// File: rtl/date_advance_seq_if.sv
// Request/result bundle for the shared date-arithmetic unit.
// The requester drives the master side; date_advance_seq uses the slave side.
interface date_advance_seq_if #(
  parameter int N_W  = 10,
  parameter int YC_W = 8
);
  logic            start;
  logic [4:0]      day_in;
  logic [3:0]      month_in;
  logic [N_W-1:0]  n_in;
  logic            leap_in;
  logic            busy;
  logic            done;
  logic            err;
  logic            ovf;
  logic [4:0]      day_out;
  logic [3:0]      month_out;
  logic [YC_W-1:0] year_carry;

  modport master (
    output start, day_in, month_in, n_in, leap_in,
    input  busy, done, err, ovf, day_out, month_out, year_carry
  );

  modport slave (
    input  start, day_in, month_in, n_in, leap_in,
    output busy, done, err, ovf, day_out, month_out, year_carry
  );
endinterface

// File: rtl/date_advance_seq.sv
// Adds a day offset to a (day, month) date, one month boundary per cycle.
// Latency is k+1 cycles for k boundaries crossed; start is ignored while busy.
module date_advance_seq #(
  parameter int DAYS_PER_MONTH  = 30,
  parameter int MONTHS_PER_YEAR = 12,
  parameter int CAL_MODE        = 0,
  parameter int N_W             = 10,
  parameter int YC_W            = 8
) (
  input  logic         clk,
  input  logic         rst,
  date_advance_seq_if.slave bus
);

  localparam int AW = (N_W > 5) ? N_W + 1 : 6;
  localparam logic [3:0] M = (CAL_MODE == 1) ? 4'd12 : 4'(MONTHS_PER_YEAR);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
    logic [4:0] r;
    r = 5'd31;
    if (CAL_MODE == 0) begin
      r = 5'(DAYS_PER_MONTH);
    end else begin
      case (m)
        4'd2:                    r = lp ? 5'd29 : 5'd28;
        4'd4, 4'd6, 4'd9, 4'd11: r = 5'd30;
        default:                 r = 5'd31;
      endcase
    end
    return r;
  endfunction

  logic [0:0]      state;
  logic [AW-1:0]   acc;
  logic [3:0]      mon;
  logic [YC_W-1:0] yc;
  logic            leap;
  logic            ovf_r;
  logic            done_r;
  logic            err_r;
  logic [4:0]      day_r;
  logic [3:0]      month_r;
  logic [YC_W-1:0] yc_r;

  logic [4:0] in_len;
  logic [4:0] cur_len;
  logic       in_ok;
  logic       step;

  always_comb begin
    in_len  = mlen(bus.month_in, bus.leap_in);
    cur_len = mlen(mon, leap);
    in_ok   = (bus.month_in != 4'd0) && (bus.month_in <= M) &&
              (bus.day_in != 5'd0) && (bus.day_in <= in_len);
    step    = acc > AW'(cur_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mon     <= '0;
      yc      <= '0;
      leap    <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      day_r   <= '0;
      month_r <= '0;
      yc_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ovf_r <= 1'b0;
            if (in_ok) begin
              acc   <= AW'(bus.day_in) + AW'(bus.n_in);
              mon   <= bus.month_in;
              yc    <= '0;
              leap  <= bus.leap_in;
              state <= RUN;
            end else begin
              // Rejected request completes at once and echoes the inputs.
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              day_r   <= bus.day_in;
              month_r <= bus.month_in;
              yc_r    <= '0;
            end
          end
        end
        RUN: begin
          if (step) begin
            acc <= acc - AW'(cur_len);
            if (mon == M) begin
              mon  <= 4'd1;
              // Only the starting year's February can be a leap February.
              leap <= 1'b0;
              if (&yc) ovf_r <= 1'b1;
              else     yc    <= yc + YC_W'(1);
            end else begin
              mon <= mon + 4'd1;
            end
          end else begin
            day_r   <= acc[4:0];
            month_r <= mon;
            yc_r    <= yc;
            done_r  <= 1'b1;
            err_r   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.ovf        = ovf_r;
  assign bus.day_out    = day_r;
  assign bus.month_out  = month_r;
  assign bus.year_carry = yc_r;

endmodule
